// File: rtl/idecode_pkg.sv
// rtl/idecode_pkg.sv - opcodes, instruction classes and pipeline latch layouts for the ID stage
package idecode_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [5:0] OP_RR   = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_HLT  = 6'b111111;

  typedef enum logic [2:0] {
    RR_ALU  = 3'd0,
    RM_ALU  = 3'd1,
    LOAD    = 3'd2,
    STORE   = 3'd3,
    BRANCH  = 3'd4,
    HALT    = 3'd5,
    ILLEGAL = 3'd6
  } instr_type_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] npc;
  } ifid_t;

  typedef struct packed {
    logic            valid;
    instr_type_t     itype;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
  } idex_t;

  function automatic instr_type_t decode_type(input logic [5:0] op);
    case (op)
      OP_RR:                            return RR_ALU;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: return RM_ALU;
      OP_LW:                            return LOAD;
      OP_SW:                            return STORE;
      OP_BEQ, OP_BNE:                   return BRANCH;
      OP_HLT:                           return HALT;
      default:                          return ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/idecode_regfile_32x32.sv
// rtl/idecode_regfile_32x32.sv - 2R1W register file, R0 hardwired to 0; WB_BYPASS_EN forwards same-cycle writes
module regfile_32x32
  import idecode_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      i_ra_addr,
  output logic [XLEN-1:0] o_ra_data,
  input  logic [4:0]      i_rb_addr,
  output logic [XLEN-1:0] o_rb_data,
  input  logic            i_we,
  input  logic [4:0]      i_wa,
  input  logic [XLEN-1:0] i_wd
);

  logic [XLEN-1:0] r_mem [NREGS];
  logic            w_wr;

  assign w_wr = i_we && (i_wa != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[i_wa] <= i_wd;
    end
  end

`ifdef WB_BYPASS_EN
  assign o_ra_data = (i_ra_addr == 5'd0) ? '0 : (w_wr && i_wa == i_ra_addr) ? i_wd : r_mem[i_ra_addr];
  assign o_rb_data = (i_rb_addr == 5'd0) ? '0 : (w_wr && i_wa == i_rb_addr) ? i_wd : r_mem[i_rb_addr];
`else
  assign o_ra_data = (i_ra_addr == 5'd0) ? '0 : r_mem[i_ra_addr];
  assign o_rb_data = (i_rb_addr == 5'd0) ? '0 : r_mem[i_rb_addr];
`endif

endmodule

// File: rtl/idecode.sv
// rtl/idecode.sv - MIPS32 ID stage: IF/ID and ID/EX latches, decode, load-use stall; WB_BYPASS_EN in regfile
module idecode
  import idecode_pkg::*;
#(
  parameter logic [XLEN-1:0] RST_NPC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_ir,
  input  logic [XLEN-1:0] if_npc,
  input  logic            if_valid,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_mem_rd,
  input  logic [4:0]      ex_rt,
  output logic            stall,
  output logic            id_valid,
  output instr_type_t     id_type,
  output logic [XLEN-1:0] id_ir,
  output logic [XLEN-1:0] id_npc,
  output logic [XLEN-1:0] id_a,
  output logic [XLEN-1:0] id_b,
  output logic [XLEN-1:0] id_imm,
  output logic [4:0]      id_rs,
  output logic [4:0]      id_rt,
  output logic [4:0]      id_rd
);

  ifid_t           r_ifid;
  idex_t           r_idex;
  idex_t           w_dec;
  idex_t           w_bubble;
  instr_type_t     w_type;
  logic [4:0]      w_rs, w_rt;
  logic [XLEN-1:0] w_a, w_b;
  logic            w_rs_used, w_rt_used;

  assign w_type = decode_type(r_ifid.ir[31:26]);
  assign w_rs   = r_ifid.ir[25:21];
  assign w_rt   = r_ifid.ir[20:16];

  regfile_32x32 u_rf (
    .clk       (clk),
    .rst       (rst),
    .i_ra_addr (w_rs),
    .o_ra_data (w_a),
    .i_rb_addr (w_rt),
    .o_rb_data (w_b),
    .i_we      (wb_we),
    .i_wa      (wb_rd),
    .i_wd      (wb_data)
  );

  // Only source fields the instruction actually reads can create a load-use hazard.
  assign w_rs_used = (w_type != HALT) && (w_type != ILLEGAL);
  assign w_rt_used = (w_type == RR_ALU) || (w_type == STORE) || (w_type == BRANCH);
  assign stall = r_ifid.valid && ex_mem_rd && (ex_rt != 5'd0) &&
                 ((w_rs_used && ex_rt == w_rs) || (w_rt_used && ex_rt == w_rt));

  always_comb begin
    w_bubble     = '0;
    w_bubble.npc = RST_NPC;
  end

  always_comb begin
    w_dec       = '0;
    w_dec.valid = 1'b1;
    w_dec.itype = w_type;
    w_dec.ir    = r_ifid.ir;
    w_dec.npc   = r_ifid.npc;
    w_dec.a     = w_a;
    w_dec.b     = w_b;
    w_dec.imm   = {{16{r_ifid.ir[15]}}, r_ifid.ir[15:0]};
    w_dec.rs    = w_rs;
    w_dec.rt    = w_rt;
    case (w_type)
      RR_ALU:       w_dec.rd = r_ifid.ir[15:11];
      RM_ALU, LOAD: w_dec.rd = w_rt;
      default:      w_dec.rd = 5'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifid.valid <= 1'b0;
      r_ifid.ir    <= '0;
      r_ifid.npc   <= RST_NPC;
      r_idex       <= w_bubble;
    end else if (flush) begin
      r_ifid.valid <= 1'b0;
      r_idex       <= w_bubble;
    end else if (stall) begin
      r_idex       <= w_bubble;
    end else begin
      r_ifid.valid <= if_valid;
      r_ifid.ir    <= if_ir;
      r_ifid.npc   <= if_npc;
      r_idex       <= r_ifid.valid ? w_dec : w_bubble;
    end
  end

  assign id_valid = r_idex.valid;
  assign id_type  = r_idex.itype;
  assign id_ir    = r_idex.ir;
  assign id_npc   = r_idex.npc;
  assign id_a     = r_idex.a;
  assign id_b     = r_idex.b;
  assign id_imm   = r_idex.imm;
  assign id_rs    = r_idex.rs;
  assign id_rt    = r_idex.rt;
  assign id_rd    = r_idex.rd;

endmodule

// File: tb/tb_idecode.sv
// tb/tb_idecode.sv - directed vector bench for idecode; expectations follow WB_BYPASS_EN
module tb_idecode;
  import idecode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_ir, if_npc, wb_data;
  logic        if_valid, flush, wb_we, ex_mem_rd;
  logic [4:0]  wb_rd, ex_rt;
  logic        stall, id_valid;
  instr_type_t id_type;
  logic [31:0] id_ir, id_npc, id_a, id_b, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] npc;
    instr_type_t typ;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[8];

  idecode dut (
    .clk(clk), .rst(rst), .if_ir(if_ir), .if_npc(if_npc), .if_valid(if_valid),
    .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_mem_rd(ex_mem_rd), .ex_rt(ex_rt), .stall(stall), .id_valid(id_valid),
    .id_type(id_type), .id_ir(id_ir), .id_npc(id_npc), .id_a(id_a), .id_b(id_b),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [31:0] ir, input logic [31:0] npc);
    if_ir    = ir;
    if_npc   = npc;
    if_valid = 1'b1;
    tick();
    if_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_byp;
    vecs[0] = '{32'h20220005, 32'h4,  RM_ALU,  32'h5,        5'd1, 5'd2, 5'd2};
    vecs[1] = '{32'h00441820, 32'h8,  RR_ALU,  32'h1820,     5'd2, 5'd4, 5'd3};
    vecs[2] = '{32'h8C430010, 32'hC,  LOAD,    32'h10,       5'd2, 5'd3, 5'd3};
    vecs[3] = '{32'hAC430010, 32'h10, STORE,   32'h10,       5'd2, 5'd3, 5'd0};
    vecs[4] = '{32'h10430004, 32'h14, BRANCH,  32'h4,        5'd2, 5'd3, 5'd0};
    vecs[5] = '{32'hF8000000, 32'h18, ILLEGAL, 32'h0,        5'd0, 5'd0, 5'd0};
    vecs[6] = '{32'hFC000000, 32'h1C, HALT,    32'h0,        5'd0, 5'd0, 5'd0};
    vecs[7] = '{32'h20228000, 32'h20, RM_ALU,  32'hFFFF8000, 5'd1, 5'd2, 5'd2};

    rst = 1'b1; if_ir = '0; if_npc = '0; if_valid = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; ex_mem_rd = 1'b0; ex_rt = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_npc", id_npc, 32'd0);
    check("rst_ir", id_ir, 32'd0);
    check("rst_type", 32'(id_type), 32'(RR_ALU));
    check("rst_stall", 32'(stall), 32'd0);

    for (int i = 0; i < 8; i++) begin
      load(vecs[i].ir, vecs[i].npc);
      check($sformatf("v%0d_lat", i), 32'(id_valid), 32'd0);
      tick();
      check($sformatf("v%0d_valid", i), 32'(id_valid), 32'd1);
      check($sformatf("v%0d_type", i), 32'(id_type), 32'(vecs[i].typ));
      check($sformatf("v%0d_ir", i), id_ir, vecs[i].ir);
      check($sformatf("v%0d_npc", i), id_npc, vecs[i].npc);
      check($sformatf("v%0d_imm", i), id_imm, vecs[i].imm);
      check($sformatf("v%0d_rs", i), 32'(id_rs), 32'(vecs[i].rs));
      check($sformatf("v%0d_rt", i), 32'(id_rt), 32'(vecs[i].rt));
      check($sformatf("v%0d_rd", i), 32'(id_rd), 32'(vecs[i].rd));
    end

    // Load-use on ADD r3,r2,r4
    load(32'h00441820, 32'h40);
    ex_mem_rd = 1'b1; ex_rt = 5'd2; #1;
    check("lu_stall_rs", 32'(stall), 32'd1);
    if_ir = 32'h20220005; if_valid = 1'b1;
    tick();
    check("lu_bubble_valid", 32'(id_valid), 32'd0);
    check("lu_bubble_ir", id_ir, 32'd0);
    check("lu_hold", 32'(stall), 32'd1);
    ex_rt = 5'd4; #1;
    check("lu_stall_rt", 32'(stall), 32'd1);
    ex_rt = 5'd3; #1;
    check("lu_rd_nostall", 32'(stall), 32'd0);
    ex_rt = 5'd0; #1;
    check("lu_r0_nostall", 32'(stall), 32'd0);
    ex_mem_rd = 1'b0; ex_rt = 5'd2; if_valid = 1'b0; #1;
    check("lu_release", 32'(stall), 32'd0);
    tick();
    check("lu_issue_valid", 32'(id_valid), 32'd1);
    check("lu_issue_ir", id_ir, 32'h00441820);
    check("lu_issue_rs", 32'(id_rs), 32'd2);

    // RM_ALU does not read rt
    load(32'h20220005, 32'h44);
    ex_mem_rd = 1'b1; ex_rt = 5'd2; #1;
    check("rm_rt_unused", 32'(stall), 32'd0);
    ex_rt = 5'd1; #1;
    check("rm_rs_stall", 32'(stall), 32'd1);
    ex_mem_rd = 1'b0;
    tick(); tick();

    // Flush beats stall and if_valid
    load(32'h00441820, 32'h48);
    ex_mem_rd = 1'b1; ex_rt = 5'd2; #1;
    check("fl_pre_stall", 32'(stall), 32'd1);
    flush = 1'b1; if_ir = 32'h20220005; if_valid = 1'b1;
    tick();
    flush = 1'b0; if_valid = 1'b0;
    check("fl_idex_valid", 32'(id_valid), 32'd0);
    check("fl_stall_cleared", 32'(stall), 32'd0);
    ex_mem_rd = 1'b0;
    tick();
    check("fl_ifid_killed", 32'(id_valid), 32'd0);

    // Writeback then dependent decode
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    wb_we = 1'b0;
    load(32'h20A10000, 32'h50);
    tick();
    check("wb_r5_a", id_a, 32'hDEADBEEF);
    load(32'hAC050000, 32'h54);
    tick();
    check("wb_r5_b", id_b, 32'hDEADBEEF);
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h55;
    tick();
    wb_we = 1'b0;
    load(32'h20010000, 32'h58);
    tick();
    check("wb_r0_zero", id_a, 32'd0);

    // Same-cycle write and decode of r7
    load(32'h20E10000, 32'h60);
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234;
    tick();
    wb_we = 1'b0;
`ifdef WB_BYPASS_EN
    exp_byp = 32'h1234;
`else
    exp_byp = 32'h0;
`endif
    check("byp_same_cycle", id_a, exp_byp);
    load(32'h20E10000, 32'h64);
    tick();
    check("byp_after", id_a, 32'h1234);

    // Reset during a stall
    load(32'h00441820, 32'h68);
    ex_mem_rd = 1'b1; ex_rt = 5'd2; #1;
    check("rs_pre_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_stall", 32'(stall), 32'd0);
    check("rs_valid", 32'(id_valid), 32'd0);
    check("rs_npc", id_npc, 32'd0);
    ex_mem_rd = 1'b0;
    load(32'h20A10000, 32'h70);
    tick();
    check("rs_regs_cleared", id_a, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
